// File: rtl/can_tx_fifo_reader.sv
// can_tx_fifo_reader: read side of the 128-bit TX message FIFO.
// Pops one word, unpacks it into CAN frame fields and presents the frame to the
// bit-level transmitter on a valid/ready handshake. The frame is held until the
// transmitter reports done, re-presented on fail up to MAX_RETRY times, then dropped.
//
//   state   | meaning
//   IDLE    | waiting for enable and a non-empty FIFO
//   POP     | single-cycle FIFO read strobe
//   LOAD    | FIFO read data valid; capture fields or flag underflow
//   PRESENT | frame valid, waiting for transmitter ready
//   WAIT_TX | frame accepted, waiting for done/fail pulse
module can_tx_fifo_reader #(
  parameter int DATA_WIDTH = 128,
  parameter int MAX_RETRY  = 3,
  parameter int RETRY_W    = 2
) (
  input  logic                  i_sys_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  input  logic                  i_fifo_underflow,
  input  logic [DATA_WIDTH-1:0] i_fifo_r_data,
  output logic                  o_fifo_r_en,
  input  logic                  i_tx_ready,
  input  logic                  i_tx_done,
  input  logic                  i_tx_fail,
  output logic                  o_frame_valid,
  output logic [28:0]           o_tx_id,
  output logic                  o_tx_ide,
  output logic                  o_tx_rtr,
  output logic [3:0]            o_tx_dlc,
  output logic [63:0]           o_tx_data,
  output logic                  o_busy,
  output logic                  o_drop,
  output logic                  o_err_underflow,
  output logic [RETRY_W-1:0]    o_retry_cnt,
  output logic [15:0]           o_frame_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP     = 3'd1,
    LOAD    = 3'd2,
    PRESENT = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  localparam logic [RETRY_W-1:0] LP_MAX_RETRY = RETRY_W'(MAX_RETRY);

  state_t               r_state;
  logic [28:0]          r_tx_id;
  logic                 r_tx_ide;
  logic                 r_tx_rtr;
  logic [3:0]           r_tx_dlc;
  logic [63:0]          r_tx_data;
  logic                 r_drop;
  logic                 r_err_underflow;
  logic [RETRY_W-1:0]   r_retry_cnt;
  logic [15:0]          r_frame_cnt;

  // Word unpacking; the reserved field [92:64] is deliberately ignored.
  logic [28:0] w_id;
  logic        w_ide;
  logic        w_rtr;
  logic [3:0]  w_dlc;
  logic [63:0] w_data;
  logic        w_unused_rsv;

  assign w_id         = i_fifo_r_data[127:99];
  assign w_ide        = i_fifo_r_data[98];
  assign w_rtr        = i_fifo_r_data[97];
  assign w_dlc        = i_fifo_r_data[96:93];
  assign w_data       = i_fifo_r_data[63:0];
  assign w_unused_rsv = ^i_fifo_r_data[92:64];

  // Sequencer: state, captured frame fields, counters and one-cycle status pulses.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_tx_id         <= '0;
      r_tx_ide        <= 1'b0;
      r_tx_rtr        <= 1'b0;
      r_tx_dlc        <= '0;
      r_tx_data       <= '0;
      r_drop          <= 1'b0;
      r_err_underflow <= 1'b0;
      r_retry_cnt     <= '0;
      r_frame_cnt     <= '0;
    end else begin
      r_drop          <= 1'b0;
      r_err_underflow <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_enable && !i_fifo_empty) r_state <= POP;
        end
        POP: begin
          r_state <= LOAD;
        end
        LOAD: begin
          if (i_fifo_underflow) begin
            r_err_underflow <= 1'b1;
            r_state         <= IDLE;
          end else begin
            // Standard frames carry only the 11-bit ID in [28:18].
            r_tx_id     <= w_ide ? w_id : {w_id[28:18], 18'd0};
            r_tx_ide    <= w_ide;
            r_tx_rtr    <= w_rtr;
            r_tx_dlc    <= w_dlc;
            r_tx_data   <= w_rtr ? 64'd0 : w_data;
            r_retry_cnt <= '0;
            r_state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (i_tx_ready) r_state <= WAIT_TX;
        end
        WAIT_TX: begin
          // done has priority over a coincident fail.
          if (i_tx_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= IDLE;
          end else if (i_tx_fail) begin
            if (r_retry_cnt < LP_MAX_RETRY) begin
              r_retry_cnt <= r_retry_cnt + 1'b1;
              r_state     <= PRESENT;
            end else begin
              r_drop  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_fifo_r_en     = (r_state == POP);
  assign o_frame_valid   = (r_state == PRESENT);
  assign o_busy          = (r_state != IDLE);
  assign o_tx_id         = r_tx_id;
  assign o_tx_ide        = r_tx_ide;
  assign o_tx_rtr        = r_tx_rtr;
  assign o_tx_dlc        = r_tx_dlc;
  assign o_tx_data       = r_tx_data;
  assign o_drop          = r_drop;
  assign o_err_underflow = r_err_underflow;
  assign o_retry_cnt     = r_retry_cnt;
  assign o_frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_can_tx_fifo_reader.sv
// Testbench for can_tx_fifo_reader: table of frame words with expected fields,
// plus hand-written sequences for latency, retry/drop, done/fail collision,
// underflow, enable gating and mid-frame reset.
module tb_can_tx_fifo_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         empty;
  logic         underflow;
  logic [127:0] fifo_q;
  logic [127:0] fifo_word;
  logic         r_en;
  logic         ready, done, fail;
  logic         valid;
  logic [28:0]  tx_id;
  logic         tx_ide, tx_rtr;
  logic [3:0]   tx_dlc;
  logic [63:0]  tx_data;
  logic         busy, drop, err_uf;
  logic [1:0]   retry_cnt;
  logic [15:0]  frame_cnt;

  int checks = 0;
  int passes = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  // FIFO model: read data appears one clock after the pop strobe.
  always @(posedge clk) begin
    if (r_en) fifo_q <= fifo_word;
  end

  can_tx_fifo_reader #(.DATA_WIDTH(128), .MAX_RETRY(3), .RETRY_W(2)) dut (
    .i_sys_clk(clk), .i_reset(rst), .i_enable(enable), .i_fifo_empty(empty),
    .i_fifo_underflow(underflow), .i_fifo_r_data(fifo_q), .o_fifo_r_en(r_en),
    .i_tx_ready(ready), .i_tx_done(done), .i_tx_fail(fail),
    .o_frame_valid(valid), .o_tx_id(tx_id), .o_tx_ide(tx_ide), .o_tx_rtr(tx_rtr),
    .o_tx_dlc(tx_dlc), .o_tx_data(tx_data), .o_busy(busy), .o_drop(drop),
    .o_err_underflow(err_uf), .o_retry_cnt(retry_cnt), .o_frame_cnt(frame_cnt)
  );

  typedef struct {
    logic [28:0] id;
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic [28:0] rsv;
    logic [63:0] data;
    logic [28:0] e_id;
    logic [63:0] e_data;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid && n < 10) begin
      cyc();
      n++;
    end
    chk("valid_timeout", {63'd0, valid}, 64'd1);
  endtask

  // Push one word into the FIFO model and wait for it to be presented.
  task automatic present(input logic [127:0] w);
    fifo_word = w;
    empty = 1'b0;
    cyc();
    empty = 1'b1;
    wait_valid();
  endtask

  task automatic accept();
    ready = 1'b1;
    cyc();
    ready = 1'b0;
  endtask

  task automatic pulse(input logic d, input logic f);
    done = d;
    fail = f;
    cyc();
    done = 1'b0;
    fail = 1'b0;
  endtask

  function automatic logic [127:0] mkword(input vec_t v);
    return {v.id, v.ide, v.rtr, v.dlc, v.rsv, v.data};
  endfunction

  initial begin
    vec_t v;
    int   rcount;

    vecs[0] = '{29'h048C0000, 1'b0, 1'b0, 4'd8,  29'h0,        64'h0102030405060708, 29'h048C0000, 64'h0102030405060708};
    vecs[1] = '{29'h1FFFFFFF, 1'b0, 1'b0, 4'd15, 29'h1FFFFFFF, 64'hDEADBEEFCAFEF00D, 29'h1FFC0000, 64'hDEADBEEFCAFEF00D};
    vecs[2] = '{29'h12345678, 1'b1, 1'b0, 4'd4,  29'h0AAAAAAA, 64'h1122334455667788, 29'h12345678, 64'h1122334455667788};
    vecs[3] = '{29'h0ABCDEF1, 1'b1, 1'b1, 4'd8,  29'h0,        64'hFFFFFFFFFFFFFFFF, 29'h0ABCDEF1, 64'h0};
    vecs[4] = '{29'h01ABCDE3, 1'b0, 1'b1, 4'd2,  29'h15555555, 64'h0123456789ABCDEF, 29'h01A80000, 64'h0};

    rst = 1'b1; enable = 1'b1; empty = 1'b1; underflow = 1'b0;
    ready = 1'b0; done = 1'b0; fail = 1'b0;
    fifo_word = '0; fifo_q = '0;
    repeat (3) cyc();
    rst = 1'b0;

    // 1: idle with empty FIFO, all outputs stay zero
    rcount = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (r_en) rcount++;
    end
    chk("idle_r_en_count", 64'(rcount), 64'd0);
    chk("reset_outputs", {valid, busy, drop, err_uf, retry_cnt, frame_cnt, tx_ide, tx_rtr, tx_dlc}, 64'd0);
    chk("reset_id", {35'd0, tx_id}, 64'd0);
    chk("reset_data", tx_data, 64'd0);

    // 2: latency of the first frame
    v = vecs[0];
    fifo_word = mkword(v);
    empty = 1'b0;
    cyc();
    empty = 1'b1;
    chk("lat_r_en_n1", {63'd0, r_en}, 64'd1);
    chk("lat_valid_n1", {63'd0, valid}, 64'd0);
    cyc();
    chk("lat_r_en_n2", {63'd0, r_en}, 64'd0);
    chk("lat_valid_n2", {63'd0, valid}, 64'd0);
    cyc();
    chk("lat_valid_n3", {63'd0, valid}, 64'd1);
    chk("lat_id", {35'd0, tx_id}, 64'h048C0000);
    chk("lat_data", tx_data, 64'h0102030405060708);
    accept();
    chk("wait_valid_low", {62'd0, valid, busy}, 64'd1);
    pulse(1'b1, 1'b0);
    exp_cnt++;
    chk("lat_frame_cnt", {48'd0, frame_cnt}, 64'(exp_cnt));
    chk("lat_busy", {63'd0, busy}, 64'd0);

    // Table-driven field unpacking
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      present(mkword(v));
      chk("vec_id",   {35'd0, tx_id},  {35'd0, v.e_id});
      chk("vec_flags", {58'd0, tx_ide, tx_rtr, tx_dlc}, {58'd0, v.ide, v.rtr, v.dlc});
      chk("vec_data", tx_data, v.e_data);
      chk("vec_retry", {62'd0, retry_cnt}, 64'd0);
      accept();
      pulse(1'b1, 1'b0);
      exp_cnt++;
      chk("vec_frame_cnt", {48'd0, frame_cnt}, 64'(exp_cnt));
    end

    // 3: three retries then drop on the fourth fail
    v = vecs[2];
    present(mkword(v));
    pulse(1'b1, 1'b0);  // done outside WAIT_TX is ignored
    chk("done_in_present_ignored", {47'd0, valid, frame_cnt}, {47'd0, 1'b1, 16'(exp_cnt)});
    accept();
    for (int k = 1; k <= 3; k++) begin
      pulse(1'b0, 1'b1);
      chk("retry_valid", {63'd0, valid}, 64'd1);
      chk("retry_cnt", {62'd0, retry_cnt}, 64'(k));
      chk("retry_id", {35'd0, tx_id}, {35'd0, v.e_id});
      accept();
    end
    pulse(1'b0, 1'b1);
    chk("drop_pulse", {61'd0, drop, busy, valid}, 64'b100);
    chk("drop_retry_cnt", {62'd0, retry_cnt}, 64'd3);
    chk("drop_frame_cnt", {48'd0, frame_cnt}, 64'(exp_cnt));
    cyc();
    chk("drop_one_cycle", {63'd0, drop}, 64'd0);

    // 4: done and fail together
    present(mkword(vecs[1]));
    accept();
    pulse(1'b1, 1'b1);
    exp_cnt++;
    chk("both_frame_cnt", {48'd0, frame_cnt}, 64'(exp_cnt));
    chk("both_flags", {60'd0, drop, busy, valid, retry_cnt == 2'd0}, 64'd1);

    // 5: underflow during LOAD
    fifo_word = mkword(vecs[0]);
    empty = 1'b0;
    cyc();
    empty = 1'b1;
    underflow = 1'b1;
    cyc();
    cyc();
    underflow = 1'b0;
    chk("uf_pulse", {61'd0, err_uf, valid, busy}, 64'b100);
    cyc();
    chk("uf_one_cycle", {61'd0, err_uf, valid, busy}, 64'd0);

    // enable low blocks popping
    enable = 1'b0;
    empty = 1'b0;
    rcount = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (r_en || busy) rcount++;
    end
    chk("enable_low_blocks", 64'(rcount), 64'd0);
    empty = 1'b1;
    enable = 1'b1;

    // 6: reset while presenting
    present(mkword(vecs[2]));
    rst = 1'b1;
    cyc();
    chk("rst_flags", {62'd0, valid, busy}, 64'd0);
    chk("rst_fields", {30'd0, tx_id, tx_ide, tx_rtr, tx_dlc}, 64'd0);
    chk("rst_data_cnt", {frame_cnt, 46'd0, retry_cnt}, 64'd0);
    rst = 1'b0;
    cyc();
    exp_cnt = 0;

    // rtr with all-ones payload after reset
    present(mkword(vecs[3]));
    chk("rtr_data_zero", tx_data, 64'd0);
    chk("rtr_dlc_raw", {60'd0, tx_dlc}, 64'd8);
    accept();
    pulse(1'b1, 1'b0);
    exp_cnt++;
    chk("post_rst_frame_cnt", {48'd0, frame_cnt}, 64'(exp_cnt));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
